mem_lsu: RTL
============

// Module: mem_lsu
// PURPOSE
//   Load/store unit of the MEM stage; sits directly downstream of exu. Takes the
//   exu_dout effective address, funct3 and rs2 store data, and runs a req/gnt/rvalid
//   handshake to data memory. It aligns store lanes, sign/zero-extends load data,
//   and stalls the pipeline until the access completes, faults or times out.
// PARAMETERS
//   TIMEOUT_CYCLES  16  cycles in REQ+RESP before abort with bus error (>=2)
// PORTS
//   i_clk            in   1   clock, all state on rising edge
//   i_rst            in   1   asynchronous, active-high reset
//   i_valid          in   1   MEM-stage instruction valid
//   i_is_load        in   1   instruction is a load
//   i_is_store       in   1   instruction is a store
//   i_funct3         in   3   width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_exu_dout       in   32  effective address, or ALU/CSR/MUL result
//   i_rs2_rd_data    in   32  store data, right-aligned
//   o_dmem_req       out  1   memory request, registered
//   o_dmem_we        out  1   1 = write
//   o_dmem_addr      out  32  word-aligned address {addr[31:2],2'b00}
//   o_dmem_wdata     out  32  lane-replicated store data
//   o_dmem_wstrb     out  4   byte enables; 0 for loads
//   i_dmem_gnt       in   1   request accepted this cycle
//   i_dmem_rvalid    in   1   load data valid
//   i_dmem_rdata     in   32  load data word
//   o_stall          out  1   hold upstream stages
//   o_mem_dout       out  32  writeback data
//   o_misaligned     out  1   1-cycle misaligned-access pulse
//   o_bus_err        out  1   1-cycle timeout pulse
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; o_dmem_req/we=0; addr/wdata/wstrb=0;
//   timeout counter=0. Registered output pulses clear. Combinational outputs follow inputs.
// - mem_op = i_valid & (i_is_load|i_is_store). Misaligned cases:
//   - H/HU with addr[0]=1
//   - W with addr[1:0]!=0
// - States IDLE, REQ, RESP:
//   - IDLE, mem_op, aligned:
//     - capture addr, we, funct3, addr[1:0]
//     - wdata: SB {4{b}}, SH {2{h}}, SW word
//     - wstrb: SB 0001<<a, SH 0011<<a, SW 1111
//     - ->REQ, o_dmem_req=1 next cycle
//   - IDLE, mem_op, misaligned: o_misaligned=1 next cycle; no request; stays IDLE.
//     The stage must hold across that edge: o_stall=1 this cycle, 0 on the pulse cycle.
//   - REQ: hold req/addr/wdata/wstrb stable until i_dmem_gnt.
//     - gnt & store: req=0, ->IDLE, access complete this cycle
//     - gnt & load: req=0, ->RESP
//   - RESP: i_dmem_rvalid -> ->IDLE, complete this cycle. rvalid in IDLE/REQ is ignored.
// - Timeout counter:
//   - clears on IDLE->REQ; counts each REQ/RESP cycle
//   - count == TIMEOUT_CYCLES-1 with no completion: abort to IDLE, req=0,
//     o_bus_err=1 next cycle
//   - completion on the same cycle as the limit wins over the abort
// - o_stall is combinational:
//   - 1 in IDLE with aligned or misaligned mem_op
//   - 1 in REQ/RESP, except on the completion cycle
//   - 0 on abort
//   - upstream must keep inputs stable while stalled
// - o_mem_dout:
//   - load completion cycle: lane = rdata >> (8*addr[1:0]), then
//     LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough
//   - otherwise i_exu_dout, with zero latency for non-memory instructions
// - Latency: store 2 cycles (1 stall); load >=3 cycles (2 stalls); each gnt/rvalid
//   wait cycle adds one. Back-to-back memory ops have 1 idle cycle between requests.
// TESTING
// - SB x=0x000000A5 @0x1003, gnt on the first REQ cycle -> wdata 0xA5A5A5A5,
//   wstrb 1000, addr 0x1000, o_stall high 1 cycle
// - LB @0x2001, rdata 0x0000F700, gnt at +1, rvalid at +2 -> o_mem_dout 0xFFFFFFF7
//   on the rvalid cycle; LBU gives 0x000000F7
// - LH @0x3001 -> o_misaligned pulses once, o_dmem_req never rises,
//   o_stall high for exactly the detect cycle
// - LW with gnt held low 3 cycles -> req/addr stable throughout;
//   o_stall released only on the rvalid cycle
// - Load with gnt but no rvalid, TIMEOUT_CYCLES=16 -> abort after 16 REQ+RESP cycles,
//   o_bus_err 1 cycle; a late rvalid is ignored
// - Assert i_rst while in RESP -> req=0 and state IDLE immediately (async);
//   the next load completes normally

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake to data memory with store lane
// replication, load extension, misalignment detection and a bus timeout.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_exu_dout,
    input  logic [31:0] i_rs2_rd_data,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wstrb,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic [31:0] o_mem_dout,
    output logic        o_misaligned,
    output logic        o_bus_err
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic          mem_op, misaligned, issue, detect, limit;
    logic          done, abort, load_done;
    logic [31:0]   wdata_nx, lane, ext;
    logic [3:0]    wstrb_nx;

    assign mem_op     = i_valid & (i_is_load | i_is_store);
    assign misaligned = ((i_funct3[1:0] == 2'b01) & i_exu_dout[0]) |
                        ((i_funct3[1:0] == 2'b10) & (i_exu_dout[1:0] != 2'b00));
    assign issue      = (state == IDLE) & mem_op & ~misaligned;
    // The pulse cycle still sees the same held instruction; do not re-detect it.
    assign detect     = (state == IDLE) & mem_op & misaligned & ~o_misaligned;
    assign limit      = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign load_done  = (state == RESP) & i_dmem_rvalid;

    always_comb begin
        wdata_nx = 32'h0;
        wstrb_nx = 4'b0000;
        if (i_is_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    wdata_nx = {4{i_rs2_rd_data[7:0]}};
                    wstrb_nx = 4'b0001 << i_exu_dout[1:0];
                end
                2'b01: begin
                    wdata_nx = {2{i_rs2_rd_data[15:0]}};
                    wstrb_nx = 4'b0011 << i_exu_dout[1:0];
                end
                default: begin
                    wdata_nx = i_rs2_rd_data;
                    wstrb_nx = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        abort    = 1'b0;
        o_stall  = 1'b0;
        case (state)
            IDLE: begin
                o_stall = issue | detect;
                if (issue) state_nx = REQ;
            end
            REQ: begin
                if (i_dmem_gnt & o_dmem_we) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (limit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    o_stall = 1'b1;
                    if (i_dmem_gnt) state_nx = RESP;
                end
            end
            RESP: begin
                if (i_dmem_rvalid) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else if (limit) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'h0;
            o_dmem_wdata <= 32'h0;
            o_dmem_wstrb <= 4'b0000;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            cnt          <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
        end else begin
            state        <= state_nx;
            o_dmem_req   <= (state_nx == REQ);
            o_misaligned <= detect;
            o_bus_err    <= abort;
            if (issue) begin
                o_dmem_we    <= i_is_store;
                o_dmem_addr  <= {i_exu_dout[31:2], 2'b00};
                o_dmem_wdata <= wdata_nx;
                o_dmem_wstrb <= wstrb_nx;
                f3_q         <= i_funct3;
                off_q        <= i_exu_dout[1:0];
                cnt          <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign lane = i_dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'h0, lane[7:0]};
            3'b101:  ext = {16'h0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    assign o_mem_dout = load_done ? ext : i_exu_dout;

endmodule
